// File: rtl/sample_discriminator_pkg.sv
// Shared types and the per-lane step function for the sample discriminator.
// The lane step is written once here and reused by every lane of the scan loop.
package sample_discriminator_pkg;

    // Trigger state machine states.
    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        HOLDOFF
    } trig_state_t;

    // Comparisons are done at a fixed width wide enough for any supported sample width.
    // Samples and thresholds are sign-extended into this width before comparison.
    localparam int unsigned CMP_WIDTH = 32;

    typedef logic signed [CMP_WIDTH-1:0] cmp_sample_t;

    // Result of evaluating one lane: state to hand to the next lane, and whether it fired.
    typedef struct packed {
        trig_state_t next_state;
        logic        fire;
    } lane_result_t;

    // One lane takes at most one transition, so a single sample can never both arm
    // and fire, even when threshold_low is above threshold_high.
    function automatic lane_result_t lane_step(
        input trig_state_t state,
        input cmp_sample_t sample,
        input cmp_sample_t thr_high,
        input cmp_sample_t thr_low
    );
        lane_result_t res;
        res.next_state = state;
        res.fire       = 1'b0;
        case (state)
            DISARMED: begin
                if (sample < thr_low) begin
                    res.next_state = ARMED;
                end
            end
            ARMED: begin
                if (sample > thr_high) begin
                    res.fire       = 1'b1;
                    // The caller decides between DISARMED and HOLDOFF from the holdoff value.
                    res.next_state = DISARMED;
                end
            end
            default: begin
                res.next_state = state;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/threshold_trigger.sv
// Rising threshold-crossing trigger with hysteresis and holdoff over a parallel
// sample stream. Emits a registered single-cycle pulse plus the lane that crossed.
module threshold_trigger
    import sample_discriminator_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned PARALLEL_SAMPLES = 2,
    parameter int unsigned TIMER_BITS       = 8,
    localparam int unsigned INDEX_WIDTH     =
        (PARALLEL_SAMPLES > 1) ? $clog2(PARALLEL_SAMPLES) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   s_valid,
    input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] s_data,
    input  logic [SAMPLE_WIDTH-1:0]                threshold_high,
    input  logic [SAMPLE_WIDTH-1:0]                threshold_low,
    input  logic [TIMER_BITS-1:0]                  holdoff,
    output logic                                   trig_pls,
    output logic [INDEX_WIDTH-1:0]                 trig_index,
    output logic                                   armed
);

    trig_state_t             state_q;
    logic [TIMER_BITS-1:0]   hold_cnt_q;
    logic                    trig_pls_q;
    logic [INDEX_WIDTH-1:0]  trig_index_q;

    trig_state_t             scan_state;
    logic                    scan_fire;
    logic [INDEX_WIDTH-1:0]  scan_index;
    lane_result_t            lane_res;
    cmp_sample_t             thr_high_ext;
    cmp_sample_t             thr_low_ext;
    cmp_sample_t             lane_sample;

    // Scan lanes oldest-first; each lane sees the state left by the previous one and
    // everything after the first firing lane is ignored.
    always_comb begin
        thr_high_ext = cmp_sample_t'($signed(threshold_high));
        thr_low_ext  = cmp_sample_t'($signed(threshold_low));
        scan_state   = state_q;
        scan_fire    = 1'b0;
        scan_index   = '0;
        lane_res     = '{next_state: state_q, fire: 1'b0};
        lane_sample  = '0;
        for (int k = 0; k < int'(PARALLEL_SAMPLES); k++) begin
            if (!scan_fire) begin
                lane_sample = cmp_sample_t'($signed(s_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
                lane_res    = lane_step(scan_state, lane_sample, thr_high_ext, thr_low_ext);
                scan_state  = lane_res.next_state;
                if (lane_res.fire) begin
                    scan_fire  = 1'b1;
                    scan_index = INDEX_WIDTH'(k);
                end
            end
        end
    end

    // Trigger FSM with holdoff counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DISARMED;
            hold_cnt_q   <= '0;
            trig_pls_q   <= 1'b0;
            trig_index_q <= '0;
        end else begin
            trig_pls_q   <= 1'b0;
            trig_index_q <= '0;
            case (state_q)
                HOLDOFF: begin
                    // Counts every cycle whether or not words arrive; words are dropped.
                    if (hold_cnt_q <= TIMER_BITS'(1)) begin
                        state_q    <= DISARMED;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - TIMER_BITS'(1);
                    end
                end
                DISARMED, ARMED: begin
                    if (s_valid) begin
                        if (scan_fire) begin
                            trig_pls_q   <= 1'b1;
                            trig_index_q <= scan_index;
                            if (holdoff == '0) begin
                                state_q <= DISARMED;
                            end else begin
                                state_q    <= HOLDOFF;
                                hold_cnt_q <= holdoff;
                            end
                        end else begin
                            state_q <= scan_state;
                        end
                    end
                end
                default: begin
                    state_q    <= DISARMED;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign trig_pls   = trig_pls_q;
    assign trig_index = trig_index_q;
    assign armed      = (state_q == ARMED);

endmodule

// File: doc/threshold_trigger.md
Name: threshold_trigger

Overview:
- Upstream trigger source for pulse_delay in the receive chain's sample discriminator.
- Scans a parallel-sample ADC stream for rising threshold crossings, with hysteresis and a configurable holdoff.
- Emits a single-cycle trig_pls, which connects directly to pulse_delay in_pls, plus the lane index of the crossing.
- Exactly one trigger per qualifying crossing; noise around threshold does not retrigger.

Parameters:
- SAMPLE_WIDTH, 16, bits per signed sample.
- PARALLEL_SAMPLES, 2, samples per word; lane 0 is the oldest.
- TIMER_BITS, 8, width of the holdoff counter; matches pulse_delay TIMER_BITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  sample word valid. No backpressure; the block is always ready.
- s_data  in  PARALLEL_SAMPLES*SAMPLE_WIDTH  signed samples; lane k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- threshold_high  in  SAMPLE_WIDTH  signed trigger level.
- threshold_low  in  SAMPLE_WIDTH  signed re-arm level.
- holdoff  in  TIMER_BITS  clock cycles to ignore input after a trigger.
- trig_pls  out  1  single-cycle trigger pulse.
- trig_index  out  $clog2(PARALLEL_SAMPLES) (min 1)  lane that triggered; valid only while trig_pls=1.
- armed  out  1  status: state==ARMED.

Behaviour:
- Thresholds and holdoff are sampled live every cycle; no shadow registers.
- States: DISARMED, ARMED, HOLDOFF. Reset state is DISARMED.
- Reset values: trig_pls=0, trig_index=0, armed=0, holdoff counter=0.
- Word evaluation happens only when s_valid=1 and state is DISARMED or ARMED. Lanes are evaluated in order 0..N-1, and the state after lane k feeds lane k+1 combinationally.
- DISARMED: if sample < threshold_low (strict, signed), go to ARMED.
- ARMED: if sample > threshold_high (strict, signed), trigger.
- Trigger on lane k:
  - Registered output: trig_pls=1 and trig_index=k in the following cycle (latency 1).
  - Lanes k+1..N-1 of that word are ignored.
  - At most one trigger per cycle.
- After a trigger:
  - holdoff=0: next state is DISARMED.
  - holdoff>0: next state is HOLDOFF, counter loaded with holdoff.
- HOLDOFF:
  - Counter decrements every clk, regardless of s_valid.
  - Any word presented while in HOLDOFF is discarded.
  - When the counter is 1, next state is DISARMED.
  - Net effect: a trigger from a word at cycle t means words at t+1..t+holdoff are discarded and the word at t+holdoff+1 is evaluated from DISARMED.
- A DISARMED-to-ARMED transition and a trigger may occur within one word on different lanes.
- If threshold_low > threshold_high, the same rules apply unchanged: a single sample cannot both arm and trigger, because each lane takes at most one transition.
- s_valid=0: state and counter behave as above; no arming or triggering occurs.
- Reset mid-holdoff or with a pending trigger: the next cycle shows reset values; no trig_pls is emitted for the word present during reset.
- trig_pls is never high for two consecutive cycles unless holdoff=0 and consecutive valid words each contain an arm followed by a crossing.

Decomposition:
- sample_discriminator_pkg holds:
  - typedef enum logic [1:0] {DISARMED, ARMED, HOLDOFF} trig_state_t
  - function lane_step(state, sample, thr_high, thr_low), returning next state and a fire bit. This function is reused by the lane loop.
- No sub-module: the lane scan is a combinational for-loop in the top module.

Test Plan (SAMPLE_WIDTH=16, PARALLEL_SAMPLES=2, thr_high=100, thr_low=50):
- First trigger after reset, holdoff=0: after reset release, send word (0,200). Required: lane 0 arms, lane 1 fires, trig_pls=1 one cycle later with trig_index=1, armed=0 afterwards.
- Hysteresis: armed; send words (200,75),(120,75),(120,40),(200,0). Required:
  - Trigger index 0 on the first word.
  - No trigger on words 2-3.
  - Word 3 lane 1 re-arms.
  - Word 4 lane 0 triggers with index 0.
- Holdoff=3: trigger at cycle t; send (0,200) every cycle. Required:
  - Words at t+1..t+3 are discarded.
  - The word at t+4 triggers with index 1.
  - trig_pls is seen at t+1 and t+5.
- s_valid gaps: armed; s_valid=0 with s_data=(200,200) for 5 cycles. Required: no trig_pls and armed stays 1. Then valid word (200,0) gives trig_index=0.
- Holdoff counts through invalid cycles: holdoff=4, trigger, then s_valid=0 for 4 cycles, then valid (0,200). Required: triggers with index 1.
- Reset mid-holdoff: holdoff=200; trigger, then reset for 1 cycle at t+10. Required:
  - Outputs return to reset values.
  - Word (0,200) right after reset triggers; holdoff is not still active.
